// File: rtl/mfcc_context_stacker.sv
// Collects MFCC coefficient frames into a ring of CTX+1 slots and streams a
// CTX-frame context window over valid/ready after every committed voiced frame.
module mfcc_context_stacker #(
    parameter int MFCBIT   = 32,
    parameter int NCOEF    = 12,
    parameter int CTX      = 5,
    parameter int VAD_GATE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [MFCBIT-1:0] x_i,
    input  logic                     dv_i,
    input  logic [4:0]               index_i,
    input  logic                     vad_i,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic signed [MFCBIT-1:0] o_data,
    output logic [5:0]               o_index,
    output logic                     o_last,
    output logic                     frame_err,
    output logic                     overrun
);
    localparam int NSLOT     = CTX + 1;
    localparam int DEPTH     = NSLOT * NCOEF;
    localparam int AW        = $clog2(DEPTH);
    localparam int SW        = $clog2(NSLOT);
    localparam int CW        = $clog2(NCOEF);
    localparam int LAST_BEAT = CTX * NCOEF - 1;

    typedef enum logic {WAIT0, FILL} asm_t;
    typedef enum logic {IDLE, SEND} emit_t;

    function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
        return (s == SW'(NSLOT - 1)) ? '0 : s + 1'b1;
    endfunction

    logic signed [MFCBIT-1:0] mem [DEPTH];

    asm_t          asm_state;
    emit_t         emit_state;
    logic          dv_prev;
    logic [4:0]    exp_idx;
    logic [SW-1:0] wr_slot;
    logic [SW-1:0] count;
    logic [SW-1:0] next_count;
    logic [SW-1:0] rd_slot;
    logic [CW-1:0] rd_coef;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    logic cap, idx_zero, xfer, last_xfer, blocked;
    logic store, seq_err, drop, complete, commit, start;

    assign cap       = dv_i && !dv_prev;
    assign idx_zero  = (index_i == 5'd0);
    assign xfer      = o_valid && o_ready;
    assign last_xfer = xfer && (o_index == 6'(LAST_BEAT));
    // A new frame may only begin once the window being streamed is finishing.
    assign blocked   = (emit_state == SEND) && !last_xfer;

    always_comb begin
        store   = 1'b0;
        seq_err = 1'b0;
        drop    = 1'b0;
        if (cap) begin
            if (asm_state == WAIT0) begin
                if (idx_zero) begin
                    drop  = blocked;
                    store = !blocked;
                end
            end else if (index_i == exp_idx) begin
                store = 1'b1;
            end else begin
                seq_err = 1'b1;
                if (idx_zero) begin
                    drop  = blocked;
                    store = !blocked;
                end
            end
        end
    end

    assign complete   = store && (asm_state == FILL) && (index_i == 5'(NCOEF - 1));
    assign commit     = complete && ((VAD_GATE == 0) || vad_i);
    assign next_count = (count == SW'(CTX)) ? count : count + 1'b1;
    assign start      = commit && (next_count == SW'(CTX)) && !blocked;

    assign wr_addr = AW'(wr_slot) * AW'(NCOEF) + AW'(index_i);
    assign rd_addr = AW'(rd_slot) * AW'(NCOEF) + AW'(rd_coef);

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_addr] <= x_i;
        end
    end

    // Assembler: sequence checking, frame commit and history bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dv_prev   <= 1'b1;
            asm_state <= WAIT0;
            exp_idx   <= '0;
            wr_slot   <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            dv_prev   <= dv_i;
            frame_err <= seq_err;
            overrun   <= drop;
            if (seq_err || drop) begin
                count <= '0;
            end
            if (store) begin
                if (complete) begin
                    asm_state <= WAIT0;
                    if (commit) begin
                        wr_slot <= slot_inc(wr_slot);
                        count   <= next_count;
                    end else begin
                        count <= '0;
                    end
                end else begin
                    asm_state <= FILL;
                    exp_idx   <= index_i + 5'd1;
                end
            end else if (seq_err || drop) begin
                asm_state <= WAIT0;
            end
        end
    end

    // Emitter: oldest slot sits two ahead of the slot just committed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            emit_state <= IDLE;
            o_valid    <= 1'b0;
            o_index    <= '0;
            rd_slot    <= '0;
            rd_coef    <= '0;
        end else if (start) begin
            emit_state <= SEND;
            o_valid    <= 1'b1;
            o_index    <= '0;
            rd_slot    <= slot_inc(slot_inc(wr_slot));
            rd_coef    <= '0;
        end else if (last_xfer) begin
            emit_state <= IDLE;
            o_valid    <= 1'b0;
            o_index    <= '0;
        end else if (xfer) begin
            o_index <= o_index + 6'd1;
            if (rd_coef == CW'(NCOEF - 1)) begin
                rd_coef <= '0;
                rd_slot <= slot_inc(rd_slot);
            end else begin
                rd_coef <= rd_coef + 1'b1;
            end
        end
    end

    assign o_data = o_valid ? mem[rd_addr] : '0;
    assign o_last = o_valid && (o_index == 6'(LAST_BEAT));

endmodule

// File: tb/tb_mfcc_context_stacker.sv
// Bench for mfcc_context_stacker: frame table plus hand-written overrun and
// mid-window reset sequences, with a queue of expected window beats.
`timescale 1ns/1ps
module tb_mfcc_context_stacker;
    localparam int MFCBIT = 32;
    localparam int NCOEF  = 12;
    localparam int CTX    = 5;
    localparam int WIN    = CTX * NCOEF;

    logic                     clk;
    logic                     reset;
    logic signed [MFCBIT-1:0] x_i;
    logic                     dv_i;
    logic [4:0]               index_i;
    logic                     vad_i;
    logic                     o_valid;
    logic                     o_ready;
    logic signed [MFCBIT-1:0] o_data;
    logic [5:0]               o_index;
    logic                     o_last;
    logic                     frame_err;
    logic                     overrun;

    mfcc_context_stacker #(
        .MFCBIT(MFCBIT), .NCOEF(NCOEF), .CTX(CTX), .VAD_GATE(1)
    ) dut (
        .clk(clk), .reset(reset), .x_i(x_i), .dv_i(dv_i), .index_i(index_i),
        .vad_i(vad_i), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .o_index(o_index), .o_last(o_last), .frame_err(frame_err),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic signed [MFCBIT-1:0] data;
        logic [5:0]               idx;
        logic                     last;
    } beat_t;

    typedef struct {
        int fnum;
        bit vad11;
        int bad_pos;
        bit exp_err;
        bit exp_win;
    } vec_t;

    beat_t exp_q[$];
    int    hist[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    beats_seen = 0;
    int    err_seen   = 0;
    int    ovr_seen   = 0;
    int    beats0, err0, ovr0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (frame_err) err_seen++;
            if (overrun) ovr_seen++;
            if (o_valid && o_ready) begin
                beat_t e;
                beats_seen++;
                check(exp_q.size() > 0, "beat_expected", longint'(o_index), -1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check(o_data == e.data, "beat_data", longint'(o_data), longint'(e.data));
                    check(o_index == e.idx, "beat_index", longint'(o_index), longint'(e.idx));
                    check(o_last == e.last, "beat_last", longint'(o_last), longint'(e.last));
                end
            end
        end
    end

    // Reference model: sliding history of committed frame numbers.
    task automatic model_commit(input int fnum, input bit ok);
        beat_t b;
        if (!ok) begin
            hist.delete();
        end else begin
            hist.push_back(fnum);
            if (hist.size() > CTX) hist.delete(0);
            if (hist.size() == CTX) begin
                for (int s = 0; s < CTX; s++) begin
                    for (int c = 0; c < NCOEF; c++) begin
                        b.data = 32'(16 * hist[s] + c);
                        b.idx  = 6'(s * NCOEF + c);
                        b.last = (s * NCOEF + c == WIN - 1);
                        exp_q.push_back(b);
                    end
                end
            end
        end
    endtask

    task automatic send_coef(input int val, input int idx, input bit vad);
        x_i     = 32'(val);
        index_i = 5'(idx);
        vad_i   = vad;
        dv_i    = 1'b1;
        @(posedge clk); #1;
        dv_i    = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int fnum, input bit vad11, input int bad_pos);
        for (int c = 0; c < NCOEF; c++) begin
            if (bad_pos >= 0 && c == bad_pos) begin
                send_coef(16 * fnum + c + 1, c + 1, 1'b1);
                break;
            end
            send_coef(16 * fnum + c, c, (c == NCOEF - 1) ? vad11 : 1'b1);
        end
    endtask

    task automatic snap();
        beats0 = beats_seen;
        err0   = err_seen;
        ovr0   = ovr_seen;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(n < 300, "window_done_timeout", n, 300);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_index(input int target);
        int n = 0;
        while (!(o_valid && o_index == 6'(target)) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check(n < 300, "wait_index_timeout", n, 300);
    endtask

    task automatic finish_frame(input string name, input bit exp_err, input bit exp_win);
        wait_done();
        check(err_seen - err0 == int'(exp_err), {name, "_frame_err"}, err_seen - err0, int'(exp_err));
        check(ovr_seen == ovr0, {name, "_overrun"}, ovr_seen - ovr0, 0);
        check(beats_seen - beats0 == (exp_win ? WIN : 0), {name, "_beats"},
              beats_seen - beats0, exp_win ? WIN : 0);
    endtask

    task automatic run_frame(input int fnum, input bit vad11, input int bad_pos,
                             input bit exp_err, input bit exp_win);
        snap();
        model_commit(fnum, (bad_pos < 0) && vad11);
        send_frame(fnum, vad11, bad_pos);
        finish_frame($sformatf("frame%0d", fnum), exp_err, exp_win);
    endtask

    vec_t vecs [19];

    initial begin
        vecs[0]  = '{0,  1'b1, -1, 1'b0, 1'b0};
        vecs[1]  = '{1,  1'b1, -1, 1'b0, 1'b0};
        vecs[2]  = '{2,  1'b1, -1, 1'b0, 1'b0};
        vecs[3]  = '{3,  1'b1, -1, 1'b0, 1'b0};
        vecs[4]  = '{4,  1'b1, -1, 1'b0, 1'b1};
        vecs[5]  = '{5,  1'b1, -1, 1'b0, 1'b1};
        vecs[6]  = '{6,  1'b1,  5, 1'b1, 1'b0};
        vecs[7]  = '{7,  1'b1, -1, 1'b0, 1'b0};
        vecs[8]  = '{8,  1'b1, -1, 1'b0, 1'b0};
        vecs[9]  = '{9,  1'b1, -1, 1'b0, 1'b0};
        vecs[10] = '{10, 1'b1, -1, 1'b0, 1'b0};
        vecs[11] = '{11, 1'b1, -1, 1'b0, 1'b1};
        vecs[12] = '{12, 1'b1, -1, 1'b0, 1'b1};
        vecs[13] = '{13, 1'b0, -1, 1'b0, 1'b0};
        vecs[14] = '{14, 1'b1, -1, 1'b0, 1'b0};
        vecs[15] = '{15, 1'b1, -1, 1'b0, 1'b0};
        vecs[16] = '{16, 1'b1, -1, 1'b0, 1'b0};
        vecs[17] = '{17, 1'b1, -1, 1'b0, 1'b0};
        vecs[18] = '{18, 1'b1, -1, 1'b0, 1'b1};

        reset   = 1'b0;
        x_i     = '0;
        dv_i    = 1'b0;
        index_i = '0;
        vad_i   = 1'b1;
        o_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(o_valid == 1'b0, "rst_valid", longint'(o_valid), 0);
        check(o_index == 6'd0, "rst_index", longint'(o_index), 0);
        check(o_last == 1'b0, "rst_last", longint'(o_last), 0);
        check(o_data == 0, "rst_data", longint'(o_data), 0);
        check(frame_err == 1'b0, "rst_frame_err", longint'(frame_err), 0);
        check(overrun == 1'b0, "rst_overrun", longint'(overrun), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            run_frame(vecs[i].fnum, vecs[i].vad11, vecs[i].bad_pos,
                      vecs[i].exp_err, vecs[i].exp_win);
        end

        // Backpressure at beat 10 while the next frame starts.
        snap();
        model_commit(19, 1'b1);
        send_frame(19, 1'b1, -1);
        wait_index(10);
        o_ready = 1'b0;
        send_coef(16 * 20, 0, 1'b1);
        check(o_index == 6'd10, "ovr_hold_index", longint'(o_index), 10);
        check(o_data == 16 * 15 + 10, "ovr_hold_data", longint'(o_data), 16 * 15 + 10);
        check(o_valid == 1'b1, "ovr_hold_valid", longint'(o_valid), 1);
        for (int c = 1; c < NCOEF; c++) send_coef(16 * 20 + c, c, 1'b1);
        check(o_index == 6'd10, "ovr_hold_index_late", longint'(o_index), 10);
        check(ovr_seen - ovr0 == 1, "ovr_pulses", ovr_seen - ovr0, 1);
        check(err_seen == err0, "ovr_frame_err", err_seen - err0, 0);
        o_ready = 1'b1;
        wait_done();
        check(beats_seen - beats0 == WIN, "ovr_beats", beats_seen - beats0, WIN);
        hist.delete();
        for (int f = 21; f <= 25; f++) run_frame(f, 1'b1, -1, 1'b0, f == 25);

        // Reset pulse at beat 20 with dv held high across release.
        snap();
        model_commit(26, 1'b1);
        send_frame(26, 1'b1, -1);
        wait_index(20);
        reset   = 1'b0;
        dv_i    = 1'b1;
        index_i = '0;
        x_i     = 32'sd999;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        hist.delete();
        check(o_valid == 1'b0, "rstmid_valid", longint'(o_valid), 0);
        check(o_index == 6'd0, "rstmid_index", longint'(o_index), 0);
        check(o_data == 0, "rstmid_data", longint'(o_data), 0);
        check(o_last == 1'b0, "rstmid_last", longint'(o_last), 0);
        check(beats_seen - beats0 == 20, "rstmid_beats", beats_seen - beats0, 20);
        repeat (3) @(posedge clk);
        #1;
        dv_i = 1'b0;
        @(posedge clk); #1;
        check(o_valid == 1'b0, "rstmid_valid_after", longint'(o_valid), 0);
        for (int f = 27; f <= 31; f++) run_frame(f, 1'b1, -1, 1'b0, f == 31);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
